// File: rtl/seg7_pkg.sv
// seg7_pkg: glyph, code, digit-select and frame-state definitions shared by the
// 7-segment scan receiver and anything that needs to decode its glyphs.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_UP    = 7'h5C;
    localparam logic [6:0] SEG_DOWN  = 7'h63;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] CODE_UP    = 4'd10;
    localparam logic [3:0] CODE_DOWN  = 4'd11;
    localparam logic [3:0] CODE_BAD   = 4'd14;
    localparam logic [3:0] CODE_BLANK = 4'd15;

    localparam logic [3:0] SEL0     = 4'b1110;
    localparam logic [3:0] SEL1     = 4'b1101;
    localparam logic [3:0] SEL2     = 4'b1011;
    localparam logic [3:0] SEL3     = 4'b0111;
    localparam logic [3:0] SEL_IDLE = 4'b1111;

    typedef enum logic [1:0] {HUNT, GOT0, GOT1, GOT2} state_e;

    // True when exactly one active-low select line is asserted.
    function automatic logic sel_single(input logic [3:0] dig);
        return dig == SEL0 || dig == SEL1 || dig == SEL2 || dig == SEL3;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational active-low {g..a} glyph to 4-bit code; unknown glyphs map to CODE_BAD.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] code_o
);

    always_comb begin
        code_o = CODE_BAD;
        case (seg_i)
            SEG_0:     code_o = 4'd0;
            SEG_1:     code_o = 4'd1;
            SEG_2:     code_o = 4'd2;
            SEG_3:     code_o = 4'd3;
            SEG_4:     code_o = 4'd4;
            SEG_5:     code_o = 4'd5;
            SEG_6:     code_o = 4'd6;
            SEG_7:     code_o = 4'd7;
            SEG_8:     code_o = 4'd8;
            SEG_9:     code_o = 4'd9;
            SEG_UP:    code_o = CODE_UP;
            SEG_DOWN:  code_o = CODE_DOWN;
            SEG_BLANK: code_o = CODE_BLANK;
            default:   code_o = CODE_BAD;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: samples a multiplexed 4-digit 7-segment scan, decodes each settled
// glyph and reassembles complete in-order frames, flagging glitches, bad glyphs and stalls.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int          SETTLE  = 16,
    parameter logic [26:0] TIMEOUT = 27'd500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] DIGIT,
    input  logic [6:0] DISPLAY,
    output logic [3:0] val0,
    output logic [3:0] val1,
    output logic [3:0] val2,
    output logic [3:0] val3,
    output logic       frame_valid,
    output logic       vals_valid,
    output logic       decode_err,
    output logic       seq_err,
    output logic       stale
);

    localparam logic [7:0] SETTLE_C = 8'(SETTLE);

    logic [10:0]      sync1_q, sync2_q, prev_q;
    logic [7:0]       cnt_q, cnt_d;
    logic             sampled_q, sampled_d;
    logic [26:0]      tmo_q, tmo_d;
    state_e           state_q, state_d;
    logic [2:0][3:0]  shadow_q, shadow_d;
    logic [3:0][3:0]  vals_q, vals_d;
    logic             frame_valid_q, vals_valid_q, decode_err_q, seq_err_q, stale_q;
    logic [3:0]       dig, code;
    logic             changed, fire, capture, dec_err, good;
    logic             adv0, adv1, adv2, frame, seq, timeout_hit;

    seg7_decode u_decode (.seg_i(sync2_q[6:0]), .code_o(code));

    assign dig     = sync2_q[10:7];
    assign changed = sync2_q != prev_q;
    // One capture per stable dwell: the sampled flag holds off repeats until the word moves.
    assign fire    = !changed && cnt_q == SETTLE_C && !sampled_q;
    assign capture = fire && dig != SEL_IDLE;
    assign dec_err = capture && (!sel_single(dig) || code == CODE_BAD);
    assign good    = capture && !dec_err;
    assign adv0    = good && dig == SEL0;
    assign adv1    = good && dig == SEL1 && state_q == GOT0;
    assign adv2    = good && dig == SEL2 && state_q == GOT1;
    assign frame   = good && dig == SEL3 && state_q == GOT2;
    assign seq     = good && !adv0 && !adv1 && !adv2 && !frame;

    assign cnt_d     = changed ? 8'd0 : (cnt_q == 8'hFF ? cnt_q : cnt_q + 8'd1);
    assign sampled_d = changed ? 1'b0 : (sampled_q | fire);
    assign tmo_d     = capture ? 27'd0 : (tmo_q == TIMEOUT ? tmo_q : tmo_q + 27'd1);
    assign timeout_hit = tmo_q != TIMEOUT && tmo_d == TIMEOUT;
    assign vals_d    = frame ? {code, shadow_q[2], shadow_q[1], shadow_q[0]} : vals_q;

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        if (adv0) begin
            state_d     = GOT0;
            shadow_d[0] = code;
        end else if (adv1) begin
            state_d     = GOT1;
            shadow_d[1] = code;
        end else if (adv2) begin
            state_d     = GOT2;
            shadow_d[2] = code;
        end else if (capture || timeout_hit) begin
            state_d = HUNT;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q       <= {SEL_IDLE, SEG_BLANK};
            sync2_q       <= {SEL_IDLE, SEG_BLANK};
            prev_q        <= {SEL_IDLE, SEG_BLANK};
            cnt_q         <= '0;
            sampled_q     <= 1'b0;
            tmo_q         <= '0;
            state_q       <= HUNT;
            shadow_q      <= '0;
            vals_q        <= '0;
            frame_valid_q <= 1'b0;
            vals_valid_q  <= 1'b0;
            decode_err_q  <= 1'b0;
            seq_err_q     <= 1'b0;
            stale_q       <= 1'b0;
        end else begin
            sync1_q       <= {DIGIT, DISPLAY};
            sync2_q       <= sync1_q;
            prev_q        <= sync2_q;
            cnt_q         <= cnt_d;
            sampled_q     <= sampled_d;
            tmo_q         <= tmo_d;
            state_q       <= state_d;
            shadow_q      <= shadow_d;
            vals_q        <= vals_d;
            frame_valid_q <= frame;
            vals_valid_q  <= frame ? 1'b1 : (timeout_hit ? 1'b0 : vals_valid_q);
            decode_err_q  <= dec_err;
            seq_err_q     <= seq;
            stale_q       <= frame ? 1'b0 : (timeout_hit | stale_q);
        end
    end

    assign val0        = vals_q[0];
    assign val1        = vals_q[1];
    assign val2        = vals_q[2];
    assign val3        = vals_q[3];
    assign frame_valid = frame_valid_q;
    assign vals_valid  = vals_valid_q;
    assign decode_err  = decode_err_q;
    assign seq_err     = seq_err_q;
    assign stale       = stale_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: table-driven scan frames plus hand sequences for glitch,
// timeout and mid-frame reset, with SETTLE=4 and TIMEOUT=1000.
module tb_seg7_scan_decoder;

    typedef struct {
        string       name;
        logic [15:0] dig;
        logic [27:0] disp;
        logic [15:0] vals;
        int          fv;
        int          se;
        int          de;
        logic        vv;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] DIGIT;
    logic [6:0] DISPLAY;
    logic [3:0] val0, val1, val2, val3;
    logic       frame_valid, vals_valid, decode_err, seq_err, stale;

    int   errors = 0, checks = 0;
    int   fv_n = 0, se_n = 0, de_n = 0, both_n = 0, cyc = 0, last_fv = 0, stale_rise = 0;
    int   b_fv, b_se, b_de;
    logic stale_prev = 1'b0;
    vec_t vecs[7];

    seg7_scan_decoder #(.SETTLE(4), .TIMEOUT(27'd1000)) dut (
        .clk(clk), .rst(rst), .DIGIT(DIGIT), .DISPLAY(DISPLAY),
        .val0(val0), .val1(val1), .val2(val2), .val3(val3),
        .frame_valid(frame_valid), .vals_valid(vals_valid),
        .decode_err(decode_err), .seq_err(seq_err), .stale(stale)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (frame_valid) begin
            fv_n++;
            last_fv = cyc;
        end
        if (seq_err) se_n++;
        if (decode_err) de_n++;
        if (seq_err && decode_err) both_n++;
        if (stale && !stale_prev) stale_rise = cyc;
        stale_prev = stale;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic snap();
        b_fv = fv_n;
        b_se = se_n;
        b_de = de_n;
    endtask

    task automatic dwell(input logic [3:0] d, input logic [6:0] s, input int n);
        DIGIT   = d;
        DISPLAY = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input int fv, input int se, input int de,
                             input logic [15:0] vals, input logic vv, input logic st);
        chk({tag, ".frames"}, fv_n - b_fv, fv);
        chk({tag, ".seq_err"}, se_n - b_se, se);
        chk({tag, ".decode_err"}, de_n - b_de, de);
        chk({tag, ".vals"}, {val0, val1, val2, val3}, vals);
        chk({tag, ".vals_valid"}, vals_valid, vv);
        chk({tag, ".stale"}, stale, st);
    endtask

    task automatic full_frame(input logic [27:0] disp);
        for (int i = 0; i < 4; i++) begin
            logic [15:0] sel;
            sel = 16'hEDB7;
            dwell(sel[15-4*i -: 4], disp[27-7*i -: 7], 50);
        end
    endtask

    initial begin
        vecs[0] = '{"scan1",    16'hEDB7, {7'h40, 7'h12, 7'h5C, 7'h24}, 16'h05A2, 1, 0, 0, 1'b1};
        vecs[1] = '{"seq",      16'hEBFF, {7'h40, 7'h40, 7'h7F, 7'h7F}, 16'h05A2, 0, 1, 0, 1'b1};
        vecs[2] = '{"scan2",    16'hEDB7, {7'h10, 7'h10, 7'h63, 7'h79}, 16'h99B1, 1, 0, 0, 1'b1};
        vecs[3] = '{"badglyph", 16'hEDFF, {7'h40, 7'h01, 7'h7F, 7'h7F}, 16'h99B1, 0, 0, 1, 1'b1};
        vecs[4] = '{"twolow",   16'hCFFF, {7'h40, 7'h7F, 7'h7F, 7'h7F}, 16'h99B1, 0, 0, 1, 1'b1};
        vecs[5] = '{"scan3",    16'hEDB7, {7'h7F, 7'h78, 7'h02, 7'h19}, 16'hF764, 1, 0, 0, 1'b1};
        vecs[6] = '{"scan4",    16'hEDB7, {7'h00, 7'h30, 7'h40, 7'h79}, 16'h8301, 1, 0, 0, 1'b1};

        rst = 1'b0; DIGIT = 4'hF; DISPLAY = 7'h7F;
        #1;
        chk("reset_outs", {val0, val1, val2, val3, frame_valid, vals_valid, decode_err, seq_err, stale}, 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("idle_no_pulse", fv_n + se_n + de_n, 0);

        for (int r = 0; r < 7; r++) begin
            snap();
            for (int i = 0; i < 4; i++)
                dwell(vecs[r].dig[15-4*i -: 4], vecs[r].disp[27-7*i -: 7], 50);
            chk_state(vecs[r].name, vecs[r].fv, vecs[r].se, vecs[r].de, vecs[r].vals, vecs[r].vv, 1'b0);
        end

        // A 2-cycle glitch on digit 1 before it has settled must not be captured.
        snap();
        dwell(4'hE, 7'h40, 50);
        dwell(4'hD, 7'h12, 2);
        dwell(4'hD, 7'h00, 2);
        dwell(4'hD, 7'h12, 46);
        dwell(4'hB, 7'h5C, 50);
        dwell(4'h7, 7'h24, 50);
        chk_state("glitch", 1, 0, 0, 16'h05A2, 1'b1, 1'b0);

        DIGIT = 4'hF; DISPLAY = 7'h7F;
        for (int i = 0; i < 1500 && !stale; i++) @(posedge clk);
        #1;
        chk("stale_set", stale, 1);
        chk("stale_vals_valid", vals_valid, 0);
        chk("stale_vals_kept", {val0, val1, val2, val3}, 16'h05A2);
        chk("stale_delay", stale_rise - last_fv, 1000);
        snap();
        full_frame({7'h40, 7'h12, 7'h5C, 7'h24});
        chk_state("recover", 1, 0, 0, 16'h05A2, 1'b1, 1'b0);

        dwell(4'hE, 7'h40, 50);
        dwell(4'hD, 7'h12, 50);
        rst = 1'b0; DIGIT = 4'hF; DISPLAY = 7'h7F;
        #1;
        chk("rst_async", {val0, val1, val2, val3, frame_valid, vals_valid, decode_err, seq_err, stale}, 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        snap();
        dwell(4'hF, 7'h7F, 10);
        dwell(4'hB, 7'h5C, 50);
        dwell(4'h7, 7'h24, 50);
        chk_state("post_rst", 0, 2, 0, 16'h0000, 1'b0, 1'b0);
        snap();
        full_frame({7'h10, 7'h10, 7'h63, 7'h79});
        chk_state("post_rst_frame", 1, 0, 0, 16'h99B1, 1'b1, 1'b0);

        chk("err_overlap", both_n, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
